hid_layer_feeder: RTL and testbench

//  Sequencer/source for the 6-lane hidden-layer MAC. Holds the 24-word input vector, 24x24 weights and 24 biases.
//  On start it drives run, data_in, weight_in and bias_in for one 103-cycle MAC pass: 24 neurons x 4 slices of 6 lanes.
//  It holds run afterwards so the MAC's 24-word result stays valid until the consumer acknowledges it.

---
 rtl/hid_pkg.sv | 45 ++++
 rtl/feeder_bias_win.sv | 29 ++
 rtl/hid_layer_feeder.sv | 227 ++++++++++++++++++++++
 tb/tb_hid_layer_feeder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// ============================================================================
//  Module   : hid_pkg
//  Purpose  : Shared sizes, state encoding and index helper for the
//             hidden-layer MAC feeder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hid_pkg;

    localparam int BIT_LENGTH  = 16;
    localparam int DATA_N      = 6;
    localparam int HID_LENGTH  = 24;
    localparam int PASS_CYCLES = 103;
    localparam int BIAS_LAG    = 6;
    localparam int HOLD_MAX    = 8;

    localparam int SLICES  = HID_LENGTH / DATA_N;
    localparam int W_ROWS  = HID_LENGTH * SLICES;
    localparam int LANES_W = DATA_N * BIT_LENGTH;
    localparam int RC_W    = 7;
    localparam int VEC_AW  = 5;
    localparam int ROW_AW  = 7;
    localparam int SLICE_W = 2;
    localparam int HC_W    = 3;

    localparam logic [RC_W-1:0] RC_STREAM_LAST = RC_W'(W_ROWS - 1);
    localparam logic [RC_W-1:0] RC_LAST        = RC_W'(PASS_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST      = HC_W'(HOLD_MAX - 1);

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_STREAM = 2'd1;
    localparam fsm_state_t ST_DRAIN  = 2'd2;
    localparam fsm_state_t ST_HOLD   = 2'd3;

    // Vector word feeding a given lane of a given slice.
    function automatic logic [VEC_AW-1:0] vec_index(input logic [SLICE_W-1:0] slice,
                                                    input int lane);
        return VEC_AW'(int'(slice) * DATA_N + lane);
    endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_bias_win.sv
// ============================================================================
//  Module   : feeder_bias_win
//  Purpose  : Maps the run-cycle index to the bias word index and the
//             window-valid flag covering each neuron's MAC capture cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module feeder_bias_win
    import hid_pkg::*;
(
    input  logic              active,
    input  logic [RC_W-1:0]   rc,
    output logic              win_valid,
    output logic [VEC_AW-1:0] bias_idx
);

    logic [RC_W-1:0] rc_off;

    always_comb begin
        rc_off    = rc - RC_W'(BIAS_LAG);
        win_valid = active && (rc >= RC_W'(BIAS_LAG))
                           && (rc <  RC_W'(BIAS_LAG + SLICES * HID_LENGTH));
        bias_idx  = VEC_AW'(rc_off >> SLICE_W);
    end

endmodule

`default_nettype wire

// File: rtl/hid_layer_feeder.sv
// ============================================================================
//  Module   : hid_layer_feeder
//  Purpose  : Holds vector/weights/biases and streams one MAC pass per start.
//             FEEDER_DBUF_EN: double-buffered vector with back-to-back passes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hid_layer_feeder
    import hid_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ack,
    input  logic                  vec_we,
    input  logic [VEC_AW-1:0]     vec_addr,
    input  logic [BIT_LENGTH-1:0] vec_wdata,
    input  logic                  w_we,
    input  logic [ROW_AW-1:0]     w_addr,
    input  logic [LANES_W-1:0]    w_wdata,
    input  logic                  b_we,
    input  logic [VEC_AW-1:0]     b_addr,
    input  logic [BIT_LENGTH-1:0] b_wdata,
    output logic                  run,
    output logic [LANES_W-1:0]    data_in,
    output logic [LANES_W-1:0]    weight_in,
    output logic [BIT_LENGTH-1:0] bias_in,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_drop
);

`ifdef FEEDER_DBUF_EN
    localparam logic DBUF_EN = 1'b1;
`else
    localparam logic DBUF_EN = 1'b0;
`endif

    fsm_state_t            state_q, state_d;
    logic [RC_W-1:0]       rc_q, rc_d;
    logic [HC_W-1:0]       hc_q, hc_d;
    logic                  pend_q, pend_d;
    logic                  start_acc;

    logic                  run_q, run_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_drop_q, wr_drop_d;
    logic [LANES_W-1:0]    data_in_q, data_in_d;
    logic [LANES_W-1:0]    weight_in_q, weight_in_d;
    logic [BIT_LENGTH-1:0] bias_in_q, bias_in_d;

    logic                  vec_wr_en, drop_set, w_wr_en, b_wr_en;
    logic                  bias_active, bias_win;
    logic [VEC_AW-1:0]     bias_idx;
    logic [VEC_AW-1:0]     lane_idx;
    logic [BIT_LENGTH-1:0] lane_word;
    logic                  lane_fwd;

    logic [LANES_W-1:0]    w_mem    [W_ROWS];
    logic [BIT_LENGTH-1:0] bias_mem [HID_LENGTH];

`ifdef FEEDER_DBUF_EN
    logic [BIT_LENGTH-1:0] vec_mem [2][HID_LENGTH];
    logic                  bank_q, bank_d;
`else
    logic [BIT_LENGTH-1:0] vec_mem [HID_LENGTH];
`endif

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        hc_d      = hc_q;
        pend_d    = pend_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: start_acc = start;
            ST_STREAM: begin
                rc_d = rc_q + RC_W'(1);
                if (rc_q == RC_STREAM_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (DBUF_EN && start) begin
                    pend_d = 1'b1;
                end
                if (rc_q != RC_LAST) begin
                    rc_d = rc_q + RC_W'(1);
                end else if (DBUF_EN && (pend_q || start)) begin
                    start_acc = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                    hc_d    = '0;
                end
            end
            ST_HOLD: begin
                if (DBUF_EN && start) begin
                    start_acc = 1'b1;
                end else if (ack || (hc_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_acc) begin
            state_d = ST_STREAM;
            rc_d    = '0;
            pend_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------ write ports
    always_comb begin
        w_wr_en = w_we && (w_addr < ROW_AW'(W_ROWS));
        b_wr_en = b_we && (b_addr < VEC_AW'(HID_LENGTH));
`ifdef FEEDER_DBUF_EN
        vec_wr_en = vec_we && (vec_addr < VEC_AW'(HID_LENGTH));
        drop_set  = 1'b0;
        bank_d    = start_acc ? ~bank_q : bank_q;
`else
        vec_wr_en = vec_we && (vec_addr < VEC_AW'(HID_LENGTH)) && (state_q == ST_IDLE);
        drop_set  = vec_we && (state_q != ST_IDLE);
`endif
        wr_drop_d = start_acc ? 1'b0 : (wr_drop_q | drop_set);
    end

    always_ff @(posedge clk) begin
`ifdef FEEDER_DBUF_EN
        if (vec_wr_en) vec_mem[~bank_q][vec_addr] <= vec_wdata;
`else
        if (vec_wr_en) vec_mem[vec_addr] <= vec_wdata;
`endif
        if (w_wr_en) w_mem[w_addr]    <= w_wdata;
        if (b_wr_en) bias_mem[b_addr] <= b_wdata;
    end

    // ------------------------------------------------------- output datapath
    assign bias_active = (state_d == ST_STREAM) || (state_d == ST_DRAIN);

    feeder_bias_win u_bias_win (
        .active    (bias_active),
        .rc        (rc_d),
        .win_valid (bias_win),
        .bias_idx  (bias_idx)
    );

    // A vector write landing on the edge that launches rc=0 must reach lane data.
    always_comb begin
        data_in_d   = '0;
        weight_in_d = '0;
        lane_idx    = '0;
        lane_word   = '0;
        lane_fwd    = 1'b0;
        if (state_d == ST_STREAM) begin
            for (int l = 0; l < DATA_N; l++) begin
                lane_idx = vec_index(rc_d[SLICE_W-1:0], l);
`ifdef FEEDER_DBUF_EN
                lane_word = vec_mem[bank_d][lane_idx];
                lane_fwd  = vec_wr_en && (bank_d != bank_q) && (vec_addr == lane_idx);
`else
                lane_word = vec_mem[lane_idx];
                lane_fwd  = vec_wr_en && (vec_addr == lane_idx);
`endif
                data_in_d[l*BIT_LENGTH +: BIT_LENGTH] = lane_fwd ? vec_wdata : lane_word;
            end
            weight_in_d = w_mem[rc_d];
        end
        bias_in_d = bias_win ? bias_mem[bias_idx] : '0;
        run_d     = (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DRAIN) && (rc_d == RC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rc_q        <= '0;
            hc_q        <= '0;
            pend_q      <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_drop_q   <= 1'b0;
            data_in_q   <= '0;
            weight_in_q <= '0;
            bias_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            hc_q        <= hc_d;
            pend_q      <= pend_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_drop_q   <= wr_drop_d;
            data_in_q   <= data_in_d;
            weight_in_q <= weight_in_d;
            bias_in_q   <= bias_in_d;
        end
    end

`ifdef FEEDER_DBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
        end
    end
`endif

    assign run       = run_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_drop   = wr_drop_q;
    assign data_in   = data_in_q;
    assign weight_in = weight_in_q;
    assign bias_in   = bias_in_q;

endmodule

`default_nettype wire

// File: tb/tb_hid_layer_feeder.sv
// ============================================================================
//  Module   : tb_hid_layer_feeder
//  Purpose  : Randomised self-checking bench for hid_layer_feeder against a
//             per-run-cycle arithmetic model of the pass.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hid_layer_feeder;

    localparam int BL  = 16;
    localparam int DN  = 6;
    localparam int HL  = 24;
    localparam int NR  = 96;
    localparam int DW  = DN * BL;
    localparam int LAST_RC = 102;
    localparam int HOLD_CYC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, ack, vec_we, w_we, b_we;
    logic [4:0]    vec_addr, b_addr;
    logic [6:0]    w_addr;
    logic [BL-1:0] vec_wdata, b_wdata;
    logic [DW-1:0] w_wdata;
    logic          run, busy, done, wr_drop;
    logic [DW-1:0] data_in, weight_in;
    logic [BL-1:0] bias_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [BL-1:0] m_vec    [HL];
    logic [BL-1:0] m_shadow [HL];
    logic [DW-1:0] m_w      [NR];
    logic [BL-1:0] m_b      [HL];
    logic          exp_drop;

    hid_layer_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ack       (ack),
        .vec_we    (vec_we),
        .vec_addr  (vec_addr),
        .vec_wdata (vec_wdata),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_wdata   (w_wdata),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .run       (run),
        .data_in   (data_in),
        .weight_in (weight_in),
        .bias_in   (bias_in),
        .busy      (busy),
        .done      (done),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected MAC inputs at run-cycle r, straight from the pass definition.
    function automatic logic [DW-1:0] exp_data(input int r);
        logic [DW-1:0] v;
        v = '0;
        if (r < NR) begin
            for (int l = 0; l < DN; l++) v[l*BL +: BL] = m_vec[(r % 4) * DN + l];
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_weight(input int r);
        return (r < NR) ? m_w[r] : '0;
    endfunction

    function automatic logic [BL-1:0] exp_bias(input int r);
        return (r >= 6 && r <= 101) ? m_b[(r - 6) / 4] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_all();
        for (int i = 0; i < HL; i++) begin
            vec_we = 1'b1; vec_addr = 5'(i); vec_wdata = m_shadow[i];
            b_we   = 1'b1; b_addr   = 5'(i); b_wdata   = m_b[i];
            tick();
        end
        vec_we = 1'b0; b_we = 1'b0;
        for (int i = 0; i < NR; i++) begin
            w_we = 1'b1; w_addr = 7'(i); w_wdata = m_w[i];
            tick();
        end
        w_we = 1'b0;
    endtask

    task automatic randomize_model();
        for (int i = 0; i < HL; i++) begin
            m_shadow[i] = 16'($urandom);
            m_b[i]      = 16'($urandom);
        end
        for (int i = 0; i < NR; i++) m_w[i] = {$urandom, $urandom, $urandom};
    endtask

    task automatic check_quiet(input string tag, input logic exp_run);
        check_val({tag, " run"},    DW'(run),       DW'(exp_run));
        check_val({tag, " busy"},   DW'(busy),      DW'(exp_run));
        check_val({tag, " done"},   DW'(done),      '0);
        check_val({tag, " data"},   data_in,        '0);
        check_val({tag, " weight"}, weight_in,      '0);
        check_val({tag, " bias"},   DW'(bias_in),   '0);
    endtask

    task automatic start_pass(input string tag, input bit with_write);
        int a;
        logic [BL-1:0] d;
        check_val({tag, " idle run"},  DW'(run),     '0);
        check_val({tag, " idle drop"}, DW'(wr_drop), DW'(exp_drop));
        start = 1'b1;
        if (with_write) begin
            a = $urandom_range(0, HL - 1);
            d = 16'($urandom);
            vec_we = 1'b1; vec_addr = 5'(a); vec_wdata = d;
            m_shadow[a] = d;
        end
        tick();
        start = 1'b0; vec_we = 1'b0;
        m_vec = m_shadow;
        exp_drop = 1'b0;
    endtask

    task automatic stream_check(input string tag, input int vwe_at, input int wwe_at,
                                input int start_lo, input int start_hi, input int ack_at,
                                input int rst_at, input bit load_shadow);
        logic [DW-1:0] new_row;
        for (int r = 0; r <= LAST_RC; r++) begin
            check_val($sformatf("%s rc%0d run", tag, r),    DW'(run),     DW'(1'b1));
            check_val($sformatf("%s rc%0d busy", tag, r),   DW'(busy),    DW'(1'b1));
            check_val($sformatf("%s rc%0d data", tag, r),   data_in,      exp_data(r));
            check_val($sformatf("%s rc%0d weight", tag, r), weight_in,    exp_weight(r));
            check_val($sformatf("%s rc%0d bias", tag, r),   DW'(bias_in), DW'(exp_bias(r)));
            check_val($sformatf("%s rc%0d done", tag, r),   DW'(done),    DW'(r == LAST_RC));
            check_val($sformatf("%s rc%0d drop", tag, r),   DW'(wr_drop), DW'(exp_drop));
            if (r == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_quiet($sformatf("%s rst", tag), 1'b0);
                check_val({tag, " rst drop"}, DW'(wr_drop), '0);
                @(negedge clk);
                rst_n = 1'b1;
                exp_drop = 1'b0;
                return;
            end
            start = (r >= start_lo) && (r <= start_hi);
            ack   = (r == ack_at);
            if (r == vwe_at) begin
                vec_we = 1'b1; vec_addr = 5'($urandom_range(0, HL - 1)); vec_wdata = 16'($urandom);
            end
            if (load_shadow && r >= 10 && r < 10 + HL) begin
                vec_we = 1'b1; vec_addr = 5'(r - 10); vec_wdata = m_shadow[r - 10];
            end
            new_row = {$urandom, $urandom, $urandom};
            if (r == wwe_at) begin
                w_we = 1'b1; w_addr = 7'(r); w_wdata = new_row;
            end
            tick();
            start = 1'b0; ack = 1'b0; vec_we = 1'b0; w_we = 1'b0;
`ifndef FEEDER_DBUF_EN
            if (r == vwe_at) exp_drop = 1'b1;
`endif
            if (r == wwe_at) m_w[r] = new_row;
        end
    endtask

    task automatic hold_phase(input string tag, input int ack_h);
        for (int h = 0; h < HOLD_CYC; h++) begin
            check_quiet($sformatf("%s hold%0d", tag, h), 1'b1);
            ack = (h == ack_h);
            tick();
            ack = 1'b0;
            if (h == ack_h) break;
        end
        check_val({tag, " post-hold run"},  DW'(run),  '0);
        check_val({tag, " post-hold busy"}, DW'(busy), '0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0; ack = 1'b0; vec_we = 1'b0; w_we = 1'b0; b_we = 1'b0;
        vec_addr = '0; w_addr = '0; b_addr = '0;
        vec_wdata = '0; w_wdata = '0; b_wdata = '0;
        exp_drop = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_quiet("reset", 1'b0);
        check_val("reset drop", DW'(wr_drop), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post-reset", 1'b0);

        // Directed pattern; start and ack in STREAM must be ignored.
        for (int i = 0; i < HL; i++) begin
            m_shadow[i] = 16'(i + 1);
            m_b[i]      = 16'(i);
        end
        for (int i = 0; i < NR; i++) m_w[i] = {DN{16'h0001}};
        load_all();
        start_pass("t1", 1'b0);
        check_val("t1 rc0 lanes", data_in, {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        stream_check("t1", -1, -1, 50, 60, 20, -1, 1'b0);
        hold_phase("t1", -1);

        // Random data, vec write together with start, weight write mid-pass, ack on hold cycle 2.
        randomize_model();
        load_all();
        start_pass("t2", 1'b1);
        stream_check("t2", -1, $urandom_range(0, NR - 1), -1, -1, -1, -1, 1'b0);
        hold_phase("t2", 2);

`ifndef FEEDER_DBUF_EN
        // Dropped vector write; next pass reuses the stored vector and new weight row.
        randomize_model();
        load_all();
        start_pass("t3", 1'b0);
        stream_check("t3", 10, $urandom_range(0, NR - 1), -1, -1, -1, -1, 1'b0);
        hold_phase("t3", 0);
        check_val("t3 sticky drop", DW'(wr_drop), DW'(1'b1));
        start_pass("t3b", 1'b0);
        stream_check("t3b", -1, -1, -1, -1, -1, -1, 1'b0);
        hold_phase("t3b", -1);
`else
        // Back-to-back passes; second uses the vector written to the shadow bank.
        randomize_model();
        load_all();
        start_pass("t5", 1'b0);
        for (int i = 0; i < HL; i++) m_shadow[i] = 16'($urandom);
        stream_check("t5a", -1, -1, 90, 100, -1, -1, 1'b1);
        m_vec = m_shadow;
        stream_check("t5b", -1, -1, -1, -1, -1, -1, 1'b0);
        hold_phase("t5b", -1);
`endif

        // Reset at rc=40, then a complete pass.
        randomize_model();
        load_all();
        start_pass("t4", 1'b0);
        stream_check("t4", -1, -1, -1, -1, -1, 40, 1'b0);
        check_quiet("t4 idle", 1'b0);
        randomize_model();
        load_all();
        start_pass("t4b", 1'b0);
        stream_check("t4b", -1, -1, -1, -1, -1, -1, 1'b0);
        hold_phase("t4b", 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
